seq_gates_pipe: RTL and testbench



---
 rtl/seq_gates_pipe_pkg.sv | 59 +++++
 rtl/seq_gates_pipe_stage.sv | 63 ++++++
 rtl/seq_gates_pipe.sv | 84 ++++++++
 tb/tb_seq_gates_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gates_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gates_pipe_pkg                                     |
// | Description : Shared types and the bitwise word-reduction function   |
// |               used by the seq_gates_pipe datapath.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seq_gates_pipe_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // Upper bounds on the operand shape the reduction function can handle.
  localparam int MAX_NBITS   = 64;
  localparam int MAX_NINPUTS = 16;
  localparam int MAX_WORDS_W = MAX_NBITS * MAX_NINPUTS;

  // Reduces the first 'ninputs' words (each 'nbits' wide, word i at bit
  // i*nbits) of a zero-padded vector. Bits above 'nbits' in the result are 0.
  function automatic logic [MAX_NBITS-1:0] reduce_words(
    input op_e                    op,
    input logic [MAX_WORDS_W-1:0] words,
    input int                     nbits,
    input int                     ninputs
  );
    logic [MAX_NBITS-1:0] mask;
    logic [MAX_NBITS-1:0] w;
    logic [MAX_NBITS-1:0] acc_and;
    logic [MAX_NBITS-1:0] acc_or;
    logic [MAX_NBITS-1:0] acc_xor;
    logic [MAX_NBITS-1:0] res;
    mask    = (nbits >= MAX_NBITS) ? '1
            : ((MAX_NBITS'(1) << nbits) - MAX_NBITS'(1));
    acc_and = mask;
    acc_or  = '0;
    acc_xor = '0;
    for (int i = 0; i < MAX_NINPUTS; i++) begin
      if (i < ninputs) begin
        w       = MAX_NBITS'(words >> (i * nbits)) & mask;
        acc_and = acc_and & w;
        acc_or  = acc_or | w;
        acc_xor = acc_xor ^ w;
      end
    end
    case (op)
      OP_AND:  res = acc_and;
      OP_OR:   res = acc_or;
      OP_XOR:  res = acc_xor;
      default: res = ~acc_and & mask;
    endcase
    return res;
  endfunction

endpackage : seq_gates_pipe_pkg
`default_nettype wire

// File: rtl/seq_gates_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gates_pipe_stage                                   |
// | Description : One bubble-collapsing valid/ready register slice       |
// |               carrying a data word and a captured reduction op.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_gates_pipe_stage
  import seq_gates_pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         up_val_i,
  output logic         up_rdy_o,
  input  logic [W-1:0] up_data_i,
  input  op_e          up_op_i,
  output logic         dn_val_o,
  input  logic         dn_rdy_i,
  output logic [W-1:0] dn_data_o,
  output op_e          dn_op_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  op_e          op_q,    op_d;

  // An empty slot always accepts; a full one accepts only while it drains.
  assign up_rdy_o  = !valid_q || dn_rdy_i;
  assign dn_val_o  = valid_q;
  assign dn_data_o = data_q;
  assign dn_op_o   = op_q;

  // Next state: reload on an open slot, otherwise hold everything.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    if (up_rdy_o) begin
      valid_d = up_val_i;
      if (up_val_i) begin
        data_d = up_data_i;
        op_d   = up_op_i;
      end
    end
  end

  // State register; reset drops any held transaction and clears payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_AND;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

endmodule : seq_gates_pipe_stage
`default_nettype wire

// File: rtl/seq_gates_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gates_pipe                                         |
// | Description : DEPTH-stage valid/ready pipeline reducing NINPUTS      |
// |               words with a per-transaction AND/OR/XOR/NAND op.       |
// |               Define SEQ_GATES_PIPE_PARITY_EN to add out_par_o.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_gates_pipe
  import seq_gates_pipe_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NINPUTS = 2,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val_i,
  output logic                       in_rdy_o,
  input  logic [NINPUTS*NBITS-1:0]   in_i,
  input  logic [1:0]                 op_i,
  output logic                       out_val_o,
  input  logic                       out_rdy_i,
  output logic [NBITS-1:0]           out_o
`ifdef SEQ_GATES_PIPE_PARITY_EN
  ,
  output logic                       out_par_o
`endif
);

  localparam int W = NINPUTS * NBITS;

  // Index k is the upstream side of stage k; index DEPTH is the output side.
  logic         w_val  [DEPTH+1];
  logic         w_rdy  [DEPTH+1];
  logic [W-1:0] w_data [DEPTH+1];
  op_e          w_op   [DEPTH+1];

  assign w_val[0]     = in_val_i;
  assign w_data[0]    = in_i;
  assign w_op[0]      = op_e'(op_i);
  assign in_rdy_o     = w_rdy[0];
  assign w_rdy[DEPTH] = out_rdy_i;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      seq_gates_pipe_stage #(
        .W (W)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .up_val_i  (w_val[k]),
        .up_rdy_o  (w_rdy[k]),
        .up_data_i (w_data[k]),
        .up_op_i   (w_op[k]),
        .dn_val_o  (w_val[k+1]),
        .dn_rdy_i  (w_rdy[k+1]),
        .dn_data_o (w_data[k+1]),
        .dn_op_o   (w_op[k+1])
      );
    end
  endgenerate

  logic [MAX_WORDS_W-1:0] w_words;
  logic [NBITS-1:0]       w_result;

  // Zero-pad the last-stage words to the reduction function's operand width.
  always_comb begin
    w_words        = '0;
    w_words[W-1:0] = w_data[DEPTH];
  end

  // Result depends only on last-stage registers, never on in_i.
  assign w_result  = NBITS'(reduce_words(w_op[DEPTH], w_words, NBITS, NINPUTS));
  assign out_val_o = w_val[DEPTH];
  assign out_o     = w_val[DEPTH] ? w_result : '0;

`ifdef SEQ_GATES_PIPE_PARITY_EN
  // out_o is already forced to zero when idle, so parity follows suit.
  assign out_par_o = ^out_o;
`endif

endmodule : seq_gates_pipe
`default_nettype wire

// File: tb/tb_seq_gates_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_gates_pipe                                      |
// | Description : Directed, table-driven self-checking bench for         |
// |               seq_gates_pipe (NBITS=8, NINPUTS=2, DEPTH=2).          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_gates_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in_w;
  logic [1:0]  op;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_w;
`ifdef SEQ_GATES_PIPE_PARITY_EN
  logic        out_par;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] w1;
    logic [7:0] w0;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  seq_gates_pipe #(
    .NBITS   (8),
    .NINPUTS (2),
    .DEPTH   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val_i  (in_val),
    .in_rdy_o  (in_rdy),
    .in_i      (in_w),
    .op_i      (op),
    .out_val_o (out_val),
    .out_rdy_i (out_rdy),
    .out_o     (out_w)
`ifdef SEQ_GATES_PIPE_PARITY_EN
    ,
    .out_par_o (out_par)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle 2 time units away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] o);
    chk({name, "_val"}, {31'd0, out_val}, {31'd0, v});
    chk({name, "_out"}, {24'd0, out_w}, {24'd0, o});
`ifdef SEQ_GATES_PIPE_PARITY_EN
    chk({name, "_par"}, {31'd0, out_par}, {31'd0, ^o});
`endif
  endtask

  task automatic drive(input logic v, input logic [7:0] w1, input logic [7:0] w0, input logic [1:0] o);
    in_val = v;
    in_w   = {w1, w0};
    op     = o;
  endtask

  initial begin
    vecs[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30};
    vecs[1] = '{8'hA5, 8'h0F, 2'b00, 8'h05};
    vecs[2] = '{8'hA5, 8'h0F, 2'b01, 8'hAF};
    vecs[3] = '{8'hA5, 8'h0F, 2'b10, 8'hAA};
    vecs[4] = '{8'hA5, 8'h0F, 2'b11, 8'hFA};
    vecs[5] = '{8'h00, 8'h00, 2'b11, 8'hFF};
    vecs[6] = '{8'hFF, 8'hFF, 2'b10, 8'h00};
    vecs[7] = '{8'h81, 8'h18, 2'b01, 8'h99};

    // Reset with a valid input presented; it must be ignored.
    reset   = 1'b1;
    out_rdy = 1'b1;
    drive(1'b1, 8'hDE, 8'hAD, 2'b11);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk_out("rst", 1'b0, 8'h00);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 1'b0, 8'h00);
      chk($sformatf("idle%0d_in_rdy", i), {31'd0, in_rdy}, 32'd1);
    end

    // Single AND: presented in one cycle, visible DEPTH edges later, one cycle only.
    drive(1'b1, 8'hF0, 8'h3C, 2'b00);
    chk("single_in_rdy", {31'd0, in_rdy}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk_out("single_t1", 1'b0, 8'h00);
    tick();
    chk_out("single_t2", 1'b1, 8'h30);
    tick();
    chk_out("single_t3", 1'b0, 8'h00);

    // Back-to-back streaming of the vector table at full throughput.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) chk_out($sformatf("vec%0d", i - 2), 1'b1, vecs[i-2].exp);
      else        chk_out($sformatf("vec_pre%0d", i), 1'b0, 8'h00);
      chk($sformatf("stream%0d_in_rdy", i), {31'd0, in_rdy}, 32'd1);
      if (i < NV) drive(1'b1, vecs[i].w1, vecs[i].w0, vecs[i].op);
      else        drive(1'b0, 8'h00, 8'h00, 2'b00);
      tick();
    end
    chk_out("stream_drained", 1'b0, 8'h00);

    // Backpressure: two slots fill, third transaction waits, then all drain in order.
    out_rdy = 1'b0;
    drive(1'b1, 8'hF0, 8'h3C, 2'b00);
    tick();
    chk("bp_rdy_after1", {31'd0, in_rdy}, 32'd1);
    chk_out("bp_after1", 1'b0, 8'h00);
    drive(1'b1, 8'hA5, 8'h0F, 2'b01);
    tick();
    chk("bp_rdy_after2", {31'd0, in_rdy}, 32'd0);
    chk_out("bp_after2", 1'b1, 8'h30);
    drive(1'b1, 8'hA5, 8'h0F, 2'b10);
    tick();
    chk("bp_rdy_stall", {31'd0, in_rdy}, 32'd0);
    chk_out("bp_hold", 1'b1, 8'h30);
    out_rdy = 1'b1;
    #1;
    chk("bp_rdy_release", {31'd0, in_rdy}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk_out("bp_res2", 1'b1, 8'hAF);
    tick();
    chk_out("bp_res3", 1'b1, 8'hAA);
    tick();
    chk_out("bp_empty", 1'b0, 8'h00);

    // Mid-flight reset: two transactions held, reset must discard both.
    out_rdy = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 2'b01);
    tick();
    drive(1'b1, 8'h0F, 8'hF0, 2'b01);
    tick();
    chk_out("mr_loaded", 1'b1, 8'hFF);
    reset = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 2'b10);
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    out_rdy = 1'b1;
    chk_out("mr_after", 1'b0, 8'h00);
    chk("mr_in_rdy", {31'd0, in_rdy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("mr_nostale%0d", i), 1'b0, 8'h00);
    end

    // Op capture: changing op after acceptance must not alter the result.
    drive(1'b1, 8'hFF, 8'h01, 2'b00);
    tick();
    drive(1'b0, 8'hFF, 8'h01, 2'b10);
    tick();
    chk_out("opcap", 1'b1, 8'h01);
    tick();
    chk_out("opcap_done", 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_gates_pipe
`default_nettype wire
